// File: rtl/vespa_execute_mc.sv
// VeSPA EXE stage: forwarding, branch/jump targets, single-cycle ALU, iterative shift-add multiplier.
// Define VESPA_EXE_DIV_EN to build the restoring DIV/REM divider into the same BUSY/DONE sequencer.
module vespa_execute_mc #(
   parameter int unsigned DATA_W   = 32,
   parameter int unsigned PC_SEL_W = 2,
   parameter int unsigned PC_ADD4  = 0
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                valid,
   input  logic                flush,
   input  logic [3:0]          op,
   input  logic                update_cc,
   input  logic                op2_sel,
   input  logic [1:0]          fwd1,
   input  logic [1:0]          fwd2,
   input  logic [DATA_W-1:0]   r1,
   input  logic [DATA_W-1:0]   r2,
   input  logic [DATA_W-1:0]   alu_out_mem,
   input  logic [DATA_W-1:0]   rf_wb,
   input  logic [DATA_W-1:0]   imm22_mem,
   input  logic [DATA_W-1:0]   imm16,
   input  logic [DATA_W-1:0]   imm17,
   input  logic [DATA_W-1:0]   imm23,
   input  logic [DATA_W-1:0]   pc,
   input  logic [PC_SEL_W-1:0] pc_sel,
   input  logic                branch_bit,
   input  logic                branch_taken,
   output logic                stall,
   output logic                res_valid,
   output logic [DATA_W-1:0]   alu_out,
   output logic [DATA_W-1:0]   alu_op2,
   output logic [DATA_W-1:0]   imm_opx,
   output logic [DATA_W-1:0]   pc_jmp,
   output logic [DATA_W-1:0]   pc_branch,
   output logic [PC_SEL_W-1:0] next_pc_sel,
   output logic [3:0]          cc
);

   localparam int unsigned CntW = $clog2(DATA_W);

   typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

   state_e            state_q;
   logic [CntW-1:0]   cnt_q;
   logic [DATA_W-1:0] acc_q;
   logic [DATA_W-1:0] lo_q;
   logic [DATA_W-1:0] opb_q;
   logic              upd_q;
   logic              hi_sel_q;
`ifdef VESPA_EXE_DIV_EN
   logic              div_q;
   logic              div_zero_q;
   logic [DATA_W:0]   div_shift;
   logic [DATA_W:0]   div_diff;
`endif

   logic [DATA_W-1:0] op1;
   logic [DATA_W-1:0] op2_fwd;
   logic [DATA_W-1:0] op2;
   logic              is_mc;
   logic              accept;
   logic [DATA_W:0]   add_sum;
   logic [DATA_W:0]   sub_sum;
   logic [DATA_W-1:0] sc_res;
   logic              sc_c;
   logic              sc_v;
   logic              sc_legal;
   logic [3:0]        sc_cc;
   logic [DATA_W:0]   mul_sum;
   logic [DATA_W-1:0] step_acc;
   logic [DATA_W-1:0] step_lo;
   logic [DATA_W-1:0] mc_res;
   logic              mc_v;
   logic [3:0]        mc_cc;

   always_comb begin
      case (fwd1)
         2'b00:   op1 = r1;
         2'b01:   op1 = alu_out_mem;
         2'b10:   op1 = rf_wb;
         default: op1 = imm22_mem;
      endcase
      case (fwd2)
         2'b00:   op2_fwd = r2;
         2'b01:   op2_fwd = alu_out_mem;
         2'b10:   op2_fwd = rf_wb;
         default: op2_fwd = imm22_mem;
      endcase
      op2 = op2_sel ? imm16 : op2_fwd;
   end

`ifdef VESPA_EXE_DIV_EN
   assign is_mc = (op[3:2] == 2'b10);
`else
   assign is_mc = (op[3:1] == 3'b100);
`endif

   // Acceptance only looks at the registered BUSY state; the accept cycle itself raises stall.
   assign accept = valid & ~flush & (state_q != StBusy);
   assign stall  = (state_q == StBusy) | (accept & is_mc);

   always_comb begin
      add_sum  = {1'b0, op1} + {1'b0, op2};
      sub_sum  = {1'b0, op1} + {1'b0, ~op2} + (DATA_W+1)'(1);
      sc_res   = '0;
      sc_c     = 1'b0;
      sc_v     = 1'b0;
      sc_legal = 1'b1;
      case (op)
         4'd0: begin
            sc_res = add_sum[DATA_W-1:0];
            sc_c   = add_sum[DATA_W];
            sc_v   = (op1[DATA_W-1] == op2[DATA_W-1]) && (add_sum[DATA_W-1] != op1[DATA_W-1]);
         end
         4'd1: begin
            sc_res = sub_sum[DATA_W-1:0];
            sc_c   = sub_sum[DATA_W];
            sc_v   = (op1[DATA_W-1] != op2[DATA_W-1]) && (sub_sum[DATA_W-1] != op1[DATA_W-1]);
         end
         4'd2:    sc_res = op1 & op2;
         4'd3:    sc_res = op1 | op2;
         4'd4:    sc_res = op1 ^ op2;
         4'd5:    sc_res = ~op1;
         4'd6:    sc_res = op2;
         default: sc_legal = 1'b0;
      endcase
      sc_cc = {sc_c, sc_res == '0, sc_res[DATA_W-1], sc_v};
   end

   // acc_q/lo_q hold {high, low} product halves, or {remainder, quotient} when dividing.
   always_comb begin
      mul_sum  = {1'b0, acc_q} + (lo_q[0] ? {1'b0, opb_q} : '0);
      step_acc = mul_sum[DATA_W:1];
      step_lo  = {mul_sum[0], lo_q[DATA_W-1:1]};
`ifdef VESPA_EXE_DIV_EN
      div_shift = {acc_q, lo_q[DATA_W-1]};
      div_diff  = div_shift - {1'b0, opb_q};
      if (div_q) begin
         step_acc = div_diff[DATA_W] ? div_shift[DATA_W-1:0] : div_diff[DATA_W-1:0];
         step_lo  = {lo_q[DATA_W-2:0], ~div_diff[DATA_W]};
      end
`endif
      mc_res = hi_sel_q ? step_acc : step_lo;
      mc_v   = ~hi_sel_q & (step_acc != '0);
`ifdef VESPA_EXE_DIV_EN
      if (div_q) mc_v = div_zero_q;
`endif
      mc_cc = {1'b0, mc_res == '0, mc_res[DATA_W-1], mc_v};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         cnt_q       <= '0;
         acc_q       <= '0;
         lo_q        <= '0;
         opb_q       <= '0;
         upd_q       <= 1'b0;
         hi_sel_q    <= 1'b0;
`ifdef VESPA_EXE_DIV_EN
         div_q       <= 1'b0;
         div_zero_q  <= 1'b0;
`endif
         res_valid   <= 1'b0;
         alu_out     <= '0;
         alu_op2     <= '0;
         imm_opx     <= '0;
         pc_jmp      <= '0;
         pc_branch   <= '0;
         next_pc_sel <= '0;
         cc          <= '0;
      end else if (flush) begin
         state_q   <= StIdle;
         res_valid <= 1'b0;
      end else if (state_q == StBusy) begin
         acc_q     <= step_acc;
         lo_q      <= step_lo;
         cnt_q     <= cnt_q - CntW'(1);
         res_valid <= 1'b0;
         if (cnt_q == '0) begin
            state_q   <= StDone;
            res_valid <= 1'b1;
            alu_out   <= mc_res;
            if (upd_q) cc <= mc_cc;
         end
      end else begin
         state_q   <= StIdle;
         res_valid <= 1'b0;
         if (accept) begin
            alu_op2     <= op2_fwd;
            imm_opx     <= op1 + imm17;
            pc_jmp      <= op1 + imm16;
            pc_branch   <= pc + imm23;
            next_pc_sel <= (branch_bit & ~branch_taken) ? PC_SEL_W'(PC_ADD4) : pc_sel;
            if (is_mc) begin
               state_q  <= StBusy;
               cnt_q    <= CntW'(DATA_W - 1);
               acc_q    <= '0;
               lo_q     <= op1;
               opb_q    <= op2;
               upd_q    <= update_cc;
               hi_sel_q <= op[0];
`ifdef VESPA_EXE_DIV_EN
               div_q      <= op[1];
               div_zero_q <= (op2 == '0);
`endif
            end else begin
               res_valid <= 1'b1;
               alu_out   <= sc_res;
               if (update_cc && sc_legal) cc <= sc_cc;
            end
         end
      end
   end

endmodule

// File: tb/tb_vespa_execute_mc.sv
// Scoreboard bench for vespa_execute_mc: expectations pushed at issue, compared on each valid pulse.
module tb_vespa_execute_mc;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        valid = 1'b0, flush = 1'b0, update_cc = 1'b0, op2_sel = 1'b0;
   logic [3:0]  op = '0;
   logic [1:0]  fwd1 = '0, fwd2 = '0;
   logic [31:0] r1 = '0, r2 = '0, alu_out_mem = '0, rf_wb = '0, imm22_mem = '0;
   logic [31:0] imm16 = '0, imm17 = '0, imm23 = '0, pc = '0;
   logic [1:0]  pc_sel = '0;
   logic        branch_bit = 1'b0, branch_taken = 1'b0;
   logic        stall, res_valid;
   logic [31:0] alu_out, alu_op2, imm_opx, pc_jmp, pc_branch;
   logic [1:0]  next_pc_sel;
   logic [3:0]  cc;

   vespa_execute_mc #(.DATA_W(32), .PC_SEL_W(2), .PC_ADD4(0)) dut (
      .clk(clk), .rst_n(rst_n), .valid(valid), .flush(flush), .op(op), .update_cc(update_cc),
      .op2_sel(op2_sel), .fwd1(fwd1), .fwd2(fwd2), .r1(r1), .r2(r2), .alu_out_mem(alu_out_mem),
      .rf_wb(rf_wb), .imm22_mem(imm22_mem), .imm16(imm16), .imm17(imm17), .imm23(imm23),
      .pc(pc), .pc_sel(pc_sel), .branch_bit(branch_bit), .branch_taken(branch_taken),
      .stall(stall), .res_valid(res_valid), .alu_out(alu_out), .alu_op2(alu_op2),
      .imm_opx(imm_opx), .pc_jmp(pc_jmp), .pc_branch(pc_branch), .next_pc_sel(next_pc_sel),
      .cc(cc)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] res, op2, opx, jmp, br;
      logic [1:0]  psel;
      logic [3:0]  cc;
   } exp_t;

   localparam longint SMAX = 64'sd2147483647;
   localparam longint SMIN = -64'sd2147483648;

   exp_t       sb_q[$];
   int         total = 0;
   int         bad = 0;
   int         pulses = 0;
   logic [3:0] model_cc = '0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   always @(negedge clk) begin : monitor
      exp_t e;
      if (rst_n && res_valid) begin
         pulses++;
         check_eq("sb_nonempty_at_valid", 64'(sb_q.size() != 0), 64'd1);
         if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            check_eq("alu_out", 64'(alu_out), 64'(e.res));
            check_eq("cc", 64'(cc), 64'(e.cc));
            check_eq("alu_op2", 64'(alu_op2), 64'(e.op2));
            check_eq("imm_opx", 64'(imm_opx), 64'(e.opx));
            check_eq("pc_jmp", 64'(pc_jmp), 64'(e.jmp));
            check_eq("pc_branch", 64'(pc_branch), 64'(e.br));
            check_eq("next_pc_sel", 64'(next_pc_sel), 64'(e.psel));
         end
      end
   end

   task automatic predict(output exp_t e, output int ns);
      logic [31:0] a, bf, b;
      logic [63:0] p;
      longint      sa;
      logic        c, v, setcc;
      case (fwd1)
         2'd0: a = r1;   2'd1: a = alu_out_mem;   2'd2: a = rf_wb;   default: a = imm22_mem;
      endcase
      case (fwd2)
         2'd0: bf = r2;  2'd1: bf = alu_out_mem;  2'd2: bf = rf_wb;  default: bf = imm22_mem;
      endcase
      b      = op2_sel ? imm16 : bf;
      e.op2  = bf;
      e.opx  = a + imm17;
      e.jmp  = a + imm16;
      e.br   = pc + imm23;
      e.psel = (branch_bit && !branch_taken) ? 2'd0 : pc_sel;
      c = 1'b0; v = 1'b0; setcc = 1'b1; ns = 0;
      case (op)
         4'd0: begin
            e.res = a + b;
            c  = (64'(a) + 64'(b)) > 64'hFFFF_FFFF;
            sa = longint'($signed(a)) + longint'($signed(b));
            v  = (sa > SMAX) || (sa < SMIN);
         end
         4'd1: begin
            e.res = a - b;
            c  = (a >= b);
            sa = longint'($signed(a)) - longint'($signed(b));
            v  = (sa > SMAX) || (sa < SMIN);
         end
         4'd2: e.res = a & b;
         4'd3: e.res = a | b;
         4'd4: e.res = a ^ b;
         4'd5: e.res = ~a;
         4'd6: e.res = b;
         4'd8, 4'd9: begin
            p     = 64'(a) * 64'(b);
            e.res = (op == 4'd8) ? p[31:0] : p[63:32];
            v     = (op == 4'd8) && (p[63:32] != 0);
            ns    = 33;
         end
`ifdef VESPA_EXE_DIV_EN
         4'd10, 4'd11: begin
            if (b == 0) begin
               e.res = (op == 4'd10) ? 32'hFFFF_FFFF : a;
               v     = 1'b1;
            end else begin
               e.res = (op == 4'd10) ? a / b : a % b;
            end
            ns = 33;
         end
`endif
         default: begin
            e.res = '0;
            setcc = 1'b0;
         end
      endcase
      if (update_cc && setcc) model_cc = {c, e.res == 0, e.res[31], v};
      e.cc = model_cc;
   endtask

   // Called at posedge+1; returns at posedge+1 of the cycle in which the result is shown.
   task automatic fire();
      exp_t e;
      int   ns;
      int   n;
      predict(e, ns);
      sb_q.push_back(e);
      valid = 1'b1;
      n = 0;
      #1;
      if (stall) n++;
      @(posedge clk); #1;
      valid = 1'b0;
      r1 = $urandom; r2 = $urandom; alu_out_mem = $urandom; imm16 = $urandom;
      while (stall && n < 200) begin
         n++;
         @(posedge clk); #1;
      end
      check_eq("stall_cycles", 64'(n), 64'(ns));
   endtask

   task automatic set_alu(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic upd);
      op = o; r1 = a; r2 = b; update_cc = upd;
      fwd1 = 2'd0; fwd2 = 2'd0; op2_sel = 1'b0;
   endtask

   task automatic check_zero_outs(input string tag);
      check_eq({tag, "_stall"}, 64'(stall), 64'd0);
      check_eq({tag, "_valid"}, 64'(res_valid), 64'd0);
      check_eq({tag, "_alu_out"}, 64'(alu_out), 64'd0);
      check_eq({tag, "_cc"}, 64'(cc), 64'd0);
      check_eq({tag, "_others"}, 64'({alu_op2, imm_opx, pc_jmp, pc_branch, next_pc_sel} != 0), 64'd0);
   endtask

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      int p0;
      repeat (2) @(posedge clk);
      #1;
      check_zero_outs("reset");
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;

      // Signed overflow on ADD
      set_alu(4'd0, 32'h7FFF_FFFF, 32'h1, 1'b1);
      fire();
      // Forwarded SUB: MEM alu (5) - MEM imm22 (3)
      set_alu(4'd1, 32'h0, 32'h0, 1'b1);
      fwd1 = 2'd1; alu_out_mem = 32'd5; fwd2 = 2'd3; imm22_mem = 32'd3;
      fire();
      // Store data from WB while ADD uses the immediate
      set_alu(4'd0, 32'd10, 32'h0, 1'b1);
      fwd2 = 2'd2; rf_wb = 32'd9; op2_sel = 1'b1; imm16 = 32'd4;
      fire();
      // Branch not taken forces PC+4 select, taken passes it through
      set_alu(4'd2, 32'hF0F0, 32'hFF00, 1'b0);
      branch_bit = 1'b1; branch_taken = 1'b0; pc_sel = 2'd2; pc = 32'h100; imm23 = 32'hFFFF_FFF0;
      imm17 = 32'd12;
      fire();
      branch_taken = 1'b1;
      fire();
      branch_bit = 1'b0;

      // Random single-cycle and illegal ops through random forwarding paths
      for (int i = 0; i < 16; i++) begin
         logic [3:0] o;
         o = 4'($urandom_range(0, 15));
         if (o[3:2] == 2'b10) o = 4'd12 + 4'(i % 4);
         set_alu(o, $urandom, $urandom, 1'($urandom));
         fwd1 = 2'($urandom); fwd2 = 2'($urandom); op2_sel = 1'($urandom);
         alu_out_mem = $urandom; rf_wb = $urandom; imm22_mem = $urandom;
         imm16 = $urandom; imm17 = $urandom; imm23 = $urandom; pc = $urandom;
         pc_sel = 2'($urandom); branch_bit = 1'($urandom); branch_taken = 1'($urandom);
         fire();
      end
      branch_bit = 1'b0;

      // Multiplier
      set_alu(4'd8, 32'h1_0000, 32'h1_0000, 1'b1);
      fire();
      set_alu(4'd9, 32'h1_0000, 32'h1_0000, 1'b1);
      fire();
      for (int i = 0; i < 3; i++) begin
         set_alu(4'd8 + 4'(i % 2), $urandom, $urandom, 1'b1);
         fire();
      end
      set_alu(4'd8, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
      fire();

      // Divider (or illegal DIV/REM when compiled out)
      set_alu(4'd10, 32'd100, 32'd7, 1'b1);
      fire();
      set_alu(4'd11, 32'd100, 32'd7, 1'b1);
      fire();
      set_alu(4'd10, 32'd5, 32'd0, 1'b1);
      fire();
      set_alu(4'd11, 32'd5, 32'd0, 1'b1);
      fire();
      set_alu(4'd10, $urandom, 32'($urandom_range(1, 1000)), 1'b1);
      fire();

      // Flush on cycle 10 of a multiply: no result, CC held
      repeat (3) @(posedge clk);
      #1;
      p0 = pulses;
      set_alu(4'd8, 32'h1_0000, 32'h1_0000, 1'b1);
      valid = 1'b1;
      @(posedge clk); #1;
      valid = 1'b0;
      repeat (9) @(posedge clk);
      #1;
      check_eq("stall_mid_mul", 64'(stall), 64'd1);
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      check_eq("stall_after_flush", 64'(stall), 64'd0);
      // Flush beats a simultaneous accept
      set_alu(4'd0, 32'd1, 32'd1, 1'b1);
      valid = 1'b1; flush = 1'b1;
      @(posedge clk); #1;
      valid = 1'b0; flush = 1'b0;
      check_eq("flush_beats_accept", 64'(res_valid), 64'd0);
      repeat (40) @(posedge clk);
      #1;
      check_eq("no_valid_after_flush", 64'(pulses), 64'(p0));
      check_eq("cc_after_flush", 64'(cc), 64'(model_cc));

      // Reset in the middle of a multiply clears everything at once
      set_alu(4'd9, 32'hFFFF_FFFF, 32'h3, 1'b1);
      valid = 1'b1;
      @(posedge clk); #1;
      valid = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check_zero_outs("mid_mul_reset");
      model_cc = '0;
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      set_alu(4'd1, 32'd3, 32'd5, 1'b1);
      fire();

      repeat (3) @(posedge clk);
      #1;
      check_eq("sb_empty", 64'(sb_q.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
